risc_v_mike_data_mem_arbiter: RTL and testbench



---
 rtl/risc_v_mike_data_mem_arbiter.sv | 140 ++++++++++++++
 tb/tb_risc_v_mike_data_mem_arbiter.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/risc_v_mike_data_mem_arbiter.sv
// risc_v_mike_data_mem_arbiter
//
// Shares the single-port data memory between the core load/store path and the
// UART debug/loader master. At most one access reaches the memory each cycle.
// The core normally has priority. The debug master can lock the memory for
// bursts. A saturating wait counter stops the debug master from starving.
//
// Ports
//   clk, rst                    clock, synchronous active-low reset
//   core_req/we/addr/wdata      core access request
//   core_gnt                    combinational grant to the core
//   core_rvalid/rdata           registered core read return
//   dbg_req/we/addr/wdata/lock  debug access request and burst lock
//   dbg_gnt                     combinational grant to the debug master
//   dbg_rvalid/rdata            registered debug read return
//   mem_addr/write/wr_data      memory request for the winning master
//   mem_rd_data                 combinational memory read data
//   addr_err                    one-cycle pulse after an out-of-range granted access
module risc_v_mike_data_mem_arbiter #(
  parameter int DATA_MEM_DEPTH = 16,
  parameter int MAX_WAIT       = 4,
  localparam int DATA_32_W     = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 core_req,
  input  logic                 core_we,
  input  logic [DATA_32_W-1:0] core_addr,
  input  logic [DATA_32_W-1:0] core_wdata,
  output logic                 core_gnt,
  output logic                 core_rvalid,
  output logic [DATA_32_W-1:0] core_rdata,
  input  logic                 dbg_req,
  input  logic                 dbg_we,
  input  logic [DATA_32_W-1:0] dbg_addr,
  input  logic [DATA_32_W-1:0] dbg_wdata,
  input  logic                 dbg_lock,
  output logic                 dbg_gnt,
  output logic                 dbg_rvalid,
  output logic [DATA_32_W-1:0] dbg_rdata,
  output logic [DATA_32_W-1:0] mem_addr,
  output logic                 mem_write,
  output logic [DATA_32_W-1:0] mem_wr_data,
  input  logic [DATA_32_W-1:0] mem_rd_data,
  output logic                 addr_err
);

  typedef enum logic {CORE_PRI, DBG_LOCKED} state_t;

  localparam int WCNT_W = $clog2(MAX_WAIT + 1);
  localparam logic [WCNT_W-1:0]    WAIT_LIMIT  = WCNT_W'(MAX_WAIT);
  localparam logic [DATA_32_W-1:0] DEPTH_LIMIT = DATA_32_W'(DATA_MEM_DEPTH);

  state_t                 state;
  logic [WCNT_W-1:0]      wait_cnt;
  logic                   core_win;
  logic                   dbg_win;
  logic                   sel_we;
  logic [DATA_32_W-1:0]   sel_addr;
  logic [DATA_32_W-1:0]   sel_wdata;
  logic                   in_range;
  logic [DATA_32_W-1:0]   rd_value;

  // Arbitration. Grants are forced low while reset is asserted so that
  // nothing reaches the memory during reset.
  always_comb begin
    core_win = 1'b0;
    dbg_win  = 1'b0;
    if (rst) begin
      if (state == DBG_LOCKED) begin
        dbg_win  = dbg_req;
        core_win = core_req && !dbg_req;
      end else begin
        // A starved debug request beats the core once the counter saturates.
        dbg_win  = dbg_req && (!core_req || (wait_cnt >= WAIT_LIMIT));
        core_win = core_req && !dbg_win;
      end
    end
  end

  // Memory request mux. With no grant the bus is all zero.
  always_comb begin
    sel_we    = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    if (dbg_win) begin
      sel_we    = dbg_we;
      sel_addr  = dbg_addr;
      sel_wdata = dbg_wdata;
    end else if (core_win) begin
      sel_we    = core_we;
      sel_addr  = core_addr;
      sel_wdata = core_wdata;
    end
  end

  assign in_range    = sel_addr < DEPTH_LIMIT;
  assign mem_addr    = sel_addr;
  assign mem_wr_data = sel_wdata;
  // Out-of-range writes are still granted but never reach the memory.
  assign mem_write   = sel_we && in_range;
  // Out-of-range reads return zero instead of whatever the memory drives.
  assign rd_value    = in_range ? mem_rd_data : '0;
  assign core_gnt    = core_win;
  assign dbg_gnt     = dbg_win;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= CORE_PRI;
      wait_cnt    <= '0;
      core_rvalid <= 1'b0;
      dbg_rvalid  <= 1'b0;
      core_rdata  <= '0;
      dbg_rdata   <= '0;
      addr_err    <= 1'b0;
    end else begin
      case (state)
        CORE_PRI:   if (dbg_win && dbg_lock) state <= DBG_LOCKED;
        DBG_LOCKED: if (!dbg_lock) state <= CORE_PRI;
        default:    state <= CORE_PRI;
      endcase

      if (dbg_req && !dbg_win) begin
        if (wait_cnt < WAIT_LIMIT) wait_cnt <= wait_cnt + 1'b1;
      end else begin
        wait_cnt <= '0;
      end

      // Only the master whose read was granted sees rvalid; the other keeps
      // its last rdata.
      core_rvalid <= core_win && !core_we;
      dbg_rvalid  <= dbg_win && !dbg_we;
      if (core_win && !core_we) core_rdata <= rd_value;
      if (dbg_win && !dbg_we)   dbg_rdata  <= rd_value;

      addr_err <= (core_win || dbg_win) && !in_range;
    end
  end

endmodule

// File: tb/tb_risc_v_mike_data_mem_arbiter.sv
// Self-checking bench for risc_v_mike_data_mem_arbiter (DATA_MEM_DEPTH=16,
// MAX_WAIT=4). A behavioural 16-word memory sits behind the arbiter; a
// separate reference copy tracks expected contents. Read results are pushed
// to per-master queues when a read is granted and popped when rvalid is due.
module tb_risc_v_mike_data_mem_arbiter;

  logic        clk;
  logic        rst;
  logic        core_req, core_we;
  logic [31:0] core_addr, core_wdata;
  logic        core_gnt, core_rvalid;
  logic [31:0] core_rdata;
  logic        dbg_req, dbg_we, dbg_lock;
  logic [31:0] dbg_addr, dbg_wdata;
  logic        dbg_gnt, dbg_rvalid;
  logic [31:0] dbg_rdata;
  logic [31:0] mem_addr, mem_wr_data, mem_rd_data;
  logic        mem_write;
  logic        addr_err;

  int n_cmp = 0;
  int n_err = 0;

  logic [31:0] mem     [16];
  logic [31:0] ref_mem [16];
  logic [31:0] core_q [$];
  logic [31:0] dbg_q  [$];
  logic [31:0] last_core, last_dbg;

  risc_v_mike_data_mem_arbiter #(.DATA_MEM_DEPTH(16), .MAX_WAIT(4)) dut (
    .clk(clk), .rst(rst),
    .core_req(core_req), .core_we(core_we), .core_addr(core_addr), .core_wdata(core_wdata),
    .core_gnt(core_gnt), .core_rvalid(core_rvalid), .core_rdata(core_rdata),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_lock(dbg_lock), .dbg_gnt(dbg_gnt), .dbg_rvalid(dbg_rvalid), .dbg_rdata(dbg_rdata),
    .mem_addr(mem_addr), .mem_write(mem_write), .mem_wr_data(mem_wr_data),
    .mem_rd_data(mem_rd_data), .addr_err(addr_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] pattern(input int i);
    return 32'(i) * 32'h1111_1111;
  endfunction

  // Memory model: preloaded with a pattern during reset; out-of-range reads
  // return a marker value the arbiter must never pass through.
  assign mem_rd_data = (mem_addr < 32'd16) ? mem[mem_addr[3:0]] : 32'hBAD0_BAD0;
  always @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 16; i++) mem[i] <= pattern(i);
    end else if (mem_write) begin
      mem[mem_addr[3:0]] <= mem_wr_data;
    end
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // One clock cycle: check grants and the memory bus at the falling edge,
  // then check the registered outputs just after the rising edge.
  task automatic step(input string tag, input logic ec, input logic ed);
    logic        exp_crv, exp_drv, exp_err, exp_we, inr;
    logic [31:0] ea, ewd;
    @(negedge clk);
    check_val({tag, ".core_gnt"}, 32'(core_gnt), 32'(ec));
    check_val({tag, ".dbg_gnt"},  32'(dbg_gnt),  32'(ed));
    exp_crv = 1'b0; exp_drv = 1'b0; exp_err = 1'b0; exp_we = 1'b0;
    ea = '0; ewd = '0;
    if (!rst) begin
      for (int i = 0; i < 16; i++) ref_mem[i] = pattern(i);
      last_core = '0;
      last_dbg  = '0;
    end else if (ed) begin
      ea = dbg_addr; ewd = dbg_wdata; exp_we = dbg_we; exp_drv = !dbg_we;
    end else if (ec) begin
      ea = core_addr; ewd = core_wdata; exp_we = core_we; exp_crv = !core_we;
    end
    inr = ea < 32'd16;
    if (rst && (ec || ed)) begin
      exp_err = !inr;
      if (exp_we && inr) ref_mem[ea[3:0]] = ewd;
      if (exp_crv) core_q.push_back(inr ? ref_mem[ea[3:0]] : 32'h0);
      if (exp_drv) dbg_q.push_back(inr ? ref_mem[ea[3:0]] : 32'h0);
    end
    check_val({tag, ".mem_addr"},    mem_addr,    ea);
    check_val({tag, ".mem_wr_data"}, mem_wr_data, ewd);
    check_val({tag, ".mem_write"},   32'(mem_write), 32'(exp_we && inr));
    @(posedge clk);
    #1;
    check_val({tag, ".core_rvalid"}, 32'(core_rvalid), 32'(exp_crv));
    check_val({tag, ".dbg_rvalid"},  32'(dbg_rvalid),  32'(exp_drv));
    if (exp_crv) last_core = core_q.pop_front();
    if (exp_drv) last_dbg  = dbg_q.pop_front();
    check_val({tag, ".core_rdata"}, core_rdata, last_core);
    check_val({tag, ".dbg_rdata"},  dbg_rdata,  last_dbg);
    check_val({tag, ".addr_err"},   32'(addr_err), 32'(exp_err));
    $display("step %-10s core_gnt=%0b dbg_gnt=%0b mem_addr=%h we=%0b crv=%0b drv=%0b err=%0b",
             tag, ec, ed, ea, exp_we && inr, core_rvalid, dbg_rvalid, addr_err);
  endtask

  initial begin
    rst = 1'b0;
    core_req = 1'b1; core_we = 1'b0; core_addr = 32'd2; core_wdata = '0;
    dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 32'd4; dbg_wdata = '0; dbg_lock = 1'b1;
    last_core = '0; last_dbg = '0;

    // Reset with both masters requesting: no grants, outputs cleared.
    step("rst0", 1'b0, 1'b0);
    step("rst1", 1'b0, 1'b0);

    // Core alone: write then read back.
    rst = 1'b1; dbg_req = 1'b0; dbg_lock = 1'b0;
    core_we = 1'b1; core_addr = 32'd3; core_wdata = 32'hDEAD_BEEF;
    step("core_w3", 1'b1, 1'b0);
    core_we = 1'b0;
    step("core_r3", 1'b1, 1'b0);

    // Contention without lock: four core grants, then one debug grant.
    core_addr = 32'd0; dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 32'd3;
    for (int k = 0; k < 10; k++) begin
      step("contend", (k % 5) != 4, (k % 5) == 4);
      if ((k % 5) != 4) core_addr = core_addr + 32'd1;
    end

    // Lock burst: debug waits out core priority, then owns the memory.
    core_addr = 32'd1; dbg_we = 1'b1; dbg_lock = 1'b1; dbg_addr = 32'd0; dbg_wdata = 32'h100;
    for (int k = 0; k < 4; k++) step("lock_wait", 1'b1, 1'b0);
    for (int i = 0; i < 8; i++) begin
      dbg_addr = 32'(i); dbg_wdata = 32'h100 + 32'(i);
      step("burst", 1'b0, 1'b1);
    end
    // Locked but debug idle: core may use the gap.
    dbg_req = 1'b0; core_addr = 32'd5;
    step("lk_core", 1'b1, 1'b0);
    dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 32'd2;
    step("lk_dbg", 1'b0, 1'b1);

    // Reset while locked, then core priority must be back.
    rst = 1'b0;
    step("rst_lk", 1'b0, 1'b0);
    rst = 1'b1; dbg_lock = 1'b0; core_addr = 32'd6;
    step("post_rst", 1'b1, 1'b0);

    // Lock again, then drop the lock: debug wins that cycle, core next.
    core_req = 1'b0; dbg_lock = 1'b1; dbg_addr = 32'd7;
    step("relock", 1'b0, 1'b1);
    core_req = 1'b1;
    step("relock2", 1'b0, 1'b1);
    dbg_lock = 1'b0;
    step("unlock", 1'b0, 1'b1);
    step("after_unl", 1'b1, 1'b0);
    dbg_req = 1'b0;

    // Out-of-range write and read.
    core_we = 1'b1; core_addr = 32'd16; core_wdata = 32'h1234_5678;
    step("oor_w", 1'b1, 1'b0);
    core_we = 1'b0; core_addr = 32'd0;
    step("oor_chk", 1'b1, 1'b0);
    core_addr = 32'd20;
    step("oor_r", 1'b1, 1'b0);

    // Core writes, debug reads the same word the next cycle.
    core_we = 1'b1; core_addr = 32'd5; core_wdata = 32'hCAFE_0005;
    step("sim_w", 1'b1, 1'b0);
    core_req = 1'b0; core_we = 1'b0; dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 32'd5;
    step("sim_r", 1'b0, 1'b1);
    check_val("sim_r.value", dbg_rdata, 32'hCAFE_0005);
    dbg_req = 1'b0;
    step("idle", 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
